// File: rtl/div_iter_unit_pkg.sv
// Shared constants for the iterative divider: state encoding, default width,
// and slice macros for the quotient/remainder halves of div_out.
`ifndef DIV_ITER_UNIT_PKG_SV
`define DIV_ITER_UNIT_PKG_SV

`define DIV_Q_FIELD(v, w) v[2*(w)-1:(w)]
`define DIV_R_FIELD(v, w) v[(w)-1:0]

package div_iter_unit_pkg;
  localparam int DIV_DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

`endif

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it fits.
module div_step
  import div_iter_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] partial;

  assign partial = {rem_in, dividend_bit};
  assign q_bit   = (partial >= {1'b0, divisor});
  // The kept difference is always below the divisor, so W-bit arithmetic is exact.
  assign rem_out = q_bit ? (partial[DATA_W-1:0] - divisor) : partial[DATA_W-1:0];

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider serving both DIV and DIVU; returns
// {quotient, remainder} with a one-cycle res_valid, DATA_W+1 cycles after start.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                data_valid,
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   src1,
  input  logic [DATA_W-1:0]   src2,
  output logic [2*DATA_W-1:0] div_out,
  output logic                res_valid,
  output logic                busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dq;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W-1:0]   src1_orig;
  logic                q_sign;
  logic                r_sign;
  logic                div_zero;

  logic [DATA_W-1:0]   src1_mag;
  logic [DATA_W-1:0]   src2_mag;
  logic [DATA_W-1:0]   step_rem;
  logic                step_q;
  logic [DATA_W-1:0]   q_fin;
  logic [2*DATA_W-1:0] result;

  assign src1_mag = (is_signed && src1[DATA_W-1]) ? -src1 : src1;
  assign src2_mag = (is_signed && src2[DATA_W-1]) ? -src2 : src2;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in       (rem),
    .dividend_bit (dq[DATA_W-1]),
    .divisor      (divisor),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // Quotient bits shift into the dividend register as dividend bits shift out.
  assign q_fin = {dq[DATA_W-2:0], step_q};

  always_comb begin
    result = '0;
    if (div_zero) begin
      `DIV_Q_FIELD(result, DATA_W) = '1;
      `DIV_R_FIELD(result, DATA_W) = src1_orig;
    end else begin
      `DIV_Q_FIELD(result, DATA_W) = q_sign ? -q_fin : q_fin;
      `DIV_R_FIELD(result, DATA_W) = r_sign ? -step_rem : step_rem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_out   <= '0;
      dq        <= '0;
      rem       <= '0;
      divisor   <= '0;
      src1_orig <= '0;
      q_sign    <= 1'b0;
      r_sign    <= 1'b0;
      div_zero  <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_valid) begin
            dq        <= src1_mag;
            divisor   <= src2_mag;
            rem       <= '0;
            cnt       <= '0;
            src1_orig <= src1;
            q_sign    <= is_signed & (src1[DATA_W-1] ^ src2[DATA_W-1]);
            r_sign    <= is_signed & src1[DATA_W-1];
            div_zero  <= (src2 == '0);
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!data_valid) begin
            state <= S_IDLE;
          end else begin
            rem <= step_rem;
            dq  <= q_fin;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              div_out <= result;
              state   <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed corner cases plus randomized
// operands against a magnitude/sign arithmetic reference model.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        data_valid;
  logic        is_signed;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [63:0] div_out;
  logic        res_valid;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  div_iter_unit dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .data_valid (data_valid),
    .is_signed  (is_signed),
    .src1       (src1),
    .src2       (src2),
    .div_out    (div_out),
    .res_valid  (res_valid),
    .busy       (busy)
  );

  // Reference: divide magnitudes in 64-bit arithmetic, then apply the signs.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, ma, mb, qm, rm, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    qm = ma / mb;
    rm = ma % mb;
    q  = ((sa < 0) != (sb < 0)) ? -qm : qm;
    r  = (sa < 0) ? -rm : rm;
    return {q[31:0], r[31:0]};
  endfunction

  // Start a divide at the next negedge (cycle T) and report the first
  // res_valid cycle offset and the result seen there.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit churn, output logic [63:0] got, output int lat);
    @(negedge clk);
    src1 = a; src2 = b; is_signed = s; data_valid = 1'b1;
    lat = -1;
    got = 'x;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = k;
        got = div_out;
        break;
      end
      if (churn) begin
        src1 = $urandom;
        src2 = $urandom;
        is_signed = 1'($urandom);
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; data_valid = 1'b0; is_signed = 1'b0;
    src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || div_out !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_state: res_valid=%b busy=%b div_out=%h expected 0 0 0",
               res_valid, busy, div_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [63:0] got;
    int lat;
    do_div(32'd100, 32'd7, 1'b0, 1'b0, got, lat);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL unsigned_latency: got %0d expected 33", lat);
    end
    tests_run++;
    if (got !== {32'd14, 32'd2}) begin
      tests_failed++;
      $display("FAIL unsigned_100_7: got %h expected %h", got, {32'd14, 32'd2});
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL unsigned_after_done: busy=%b res_valid=%b expected 0 0", busy, res_valid);
    end
  endtask

  task automatic test_signed();
    logic [63:0] got;
    int lat;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, got, lat);
    tests_run++;
    if (got !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL signed_m7_2: got %h expected %h", got, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, got, lat);
    tests_run++;
    if (got !== {32'hFFFF_FFFD, 32'd1}) begin
      tests_failed++;
      $display("FAIL signed_7_m2: got %h expected %h", got, {32'hFFFF_FFFD, 32'd1});
    end
  endtask

  task automatic test_overflow();
    logic [63:0] got;
    int lat;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, got, lat);
    tests_run++;
    if (got !== {32'h8000_0000, 32'd0}) begin
      tests_failed++;
      $display("FAIL signed_overflow: got %h expected %h", got, {32'h8000_0000, 32'd0});
    end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, got, lat);
    tests_run++;
    if (got !== {32'd0, 32'h8000_0000}) begin
      tests_failed++;
      $display("FAIL unsigned_large: got %h expected %h", got, {32'd0, 32'h8000_0000});
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] got;
    int lat;
    for (int s = 0; s < 2; s++) begin
      do_div(32'h1234_5678, 32'd0, 1'(s), 1'b0, got, lat);
      tests_run++;
      if (lat !== 33 || got !== {32'hFFFF_FFFF, 32'h1234_5678}) begin
        tests_failed++;
        $display("FAIL div_zero_s%0d: got %h lat %0d expected %h lat 33",
                 s, got, lat, {32'hFFFF_FFFF, 32'h1234_5678});
      end
    end
  endtask

  task automatic test_flush();
    int first_k;
    logic [63:0] got;
    first_k = -1;
    got = 'x;
    @(negedge clk);
    src1 = 32'd5000; src2 = 32'd3; is_signed = 1'b0; data_valid = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (res_valid && first_k < 0) begin
        first_k = k;
        got = div_out;
      end
      if (k == 10) begin flush = 1'b1; data_valid = 1'b0; end
      if (k == 11) flush = 1'b0;
      if (k == 12) begin src1 = 32'd100; src2 = 32'd7; data_valid = 1'b1; end
      if (first_k > 0) data_valid = 1'b0;
    end
    data_valid = 1'b0;
    tests_run++;
    if (first_k !== 45 || got !== {32'd14, 32'd2}) begin
      tests_failed++;
      $display("FAIL flush_restart: got k=%0d %h expected k=45 %h", first_k, got, {32'd14, 32'd2});
    end
    @(negedge clk);
    data_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    data_valid = 1'b0; flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_blocks_start: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    bit seen_valid;
    seen_valid = 1'b0;
    @(negedge clk);
    src1 = 32'd999; src2 = 32'd10; is_signed = 1'b0; data_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (res_valid) seen_valid = 1'b1;
      if (k == 3) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL busy_during_op: busy=%b expected 1", busy);
        end
      end
      if (k == 5) data_valid = 1'b0;
      if (k == 6) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL abort_idle: busy=%b expected 0", busy);
        end
      end
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_valid: res_valid seen=%b expected 0", seen_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    src1 = 32'd12345; src2 = 32'd67; is_signed = 1'b0; data_valid = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 20) reset = 1'b1;
      if (k == 21) begin
        tests_run++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || div_out !== 64'd0) begin
          tests_failed++;
          $display("FAIL reset_mid: res_valid=%b busy=%b div_out=%h expected 0 0 0",
                   res_valid, busy, div_out);
        end
      end
    end
    reset = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [63:0] got;
    int lat;
    a = $urandom;
    b = $urandom_range(1, 1000);
    do_div(a, b, 1'b1, 1'b1, got, lat);
    tests_run++;
    if (lat !== 33 || got !== ref_div(a, b, 1'b1)) begin
      tests_failed++;
      $display("FAIL operand_churn: got %h lat %0d expected %h lat 33", got, lat, ref_div(a, b, 1'b1));
    end
    a = $urandom;
    b = $urandom;
    do_div(a, b, 1'b0, 1'b0, got, lat);
    tests_run++;
    if (lat !== 33 || got !== ref_div(a, b, 1'b0)) begin
      tests_failed++;
      $display("FAIL back_to_back: got %h lat %0d expected %h lat 33", got, lat, ref_div(a, b, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    logic [63:0] got;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = (i % 2 == 0) ? 32'd0 : $urandom_range(1, 3);
        1:       b = $urandom_range(1, 255);
        2:       b = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      do_div(a, b, s, 1'b0, got, lat);
      tests_run++;
      if (lat !== 33 || got !== ref_div(a, b, s)) begin
        tests_failed++;
        $display("FAIL random_%0d: a=%h b=%h s=%b got %h lat %0d expected %h lat 33",
                 i, a, b, s, got, lat, ref_div(a, b, s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_flush();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
